axi_line_master: RTL

AXI4 memory-side master for the complex cache. It turns one cache line request into one INCR burst on an AXI4 master port: a read line fill or a dirty line writeback. It sits between the cache controller and the AXI interconnect or AXI VIP slave memory model. Each line is held in internal buffering, so the cache sees a single request/done handshake per line.

---
 rtl/axi_line_master.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_line_master.sv
// Purpose : turns one cache-line request into a single AXI4 INCR burst (read fill or dirty writeback).
// Latency : accept -> AR/AW+W valid next cycle; fill word one cycle after each R beat; done one cycle after last R / B.
// Backpres: req_ready only in IDLE; AXI valids hold with stable payload until their handshake.
// Ports   : clk/rst (sync, active-high); req_* line request in; fill_* per-word fill out;
//           done/err completion pulse; m_axi_ar/r/aw/w/b AXI4 master channels.
module axi_line_master #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    LINE_WORDS = 4,
    parameter int                    ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0]   AXI_ID     = '0,
    localparam int                   IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [LINE_WORDS*32-1:0] req_wdata,
    output logic                     fill_valid,
    output logic [IDX_W-1:0]         fill_index,
    output logic [31:0]              fill_data,
    output logic                     done,
    output logic                     err,
    output logic [ID_WIDTH-1:0]      m_axi_arid,
    output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
    output logic [7:0]               m_axi_arlen,
    output logic [2:0]               m_axi_arsize,
    output logic [1:0]               m_axi_arburst,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [ID_WIDTH-1:0]      m_axi_rid,
    input  logic [31:0]              m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rlast,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready,
    output logic [ID_WIDTH-1:0]      m_axi_awid,
    output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
    output logic [7:0]               m_axi_awlen,
    output logic [2:0]               m_axi_awsize,
    output logic [1:0]               m_axi_awburst,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [31:0]              m_axi_wdata,
    output logic [3:0]               m_axi_wstrb,
    output logic                     m_axi_wlast,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [ID_WIDTH-1:0]      m_axi_bid,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready
);
    localparam int               OFF_W     = $clog2(LINE_WORDS * 4);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             buf_q [LINE_WORDS];
    logic [31:0]             buf_d [LINE_WORDS];
    logic [IDX_W-1:0]        beat_q, beat_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    sticky_q, sticky_d;
    logic                    fill_valid_q, fill_valid_d;
    logic [IDX_W-1:0]        fill_index_q, fill_index_d;
    logic [31:0]             fill_data_q, fill_data_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    rd_err;
    logic                    aw_done_n;
    logic                    w_done_n;

    // IDs are constant and only one burst is ever outstanding, so response IDs carry
    // no information; the line offset bits of req_addr are discarded by alignment.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_rid, m_axi_bid, req_addr[OFF_W-1:0]};

    assign req_ready     = (state_q == S_IDLE);

    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == S_RD_ADDR);
    assign m_axi_rready  = (state_q == S_RD_DATA);

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(LINE_WORDS - 1);
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state_q == S_WR) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == S_WR) && !w_done_q;
    assign m_axi_wdata   = buf_q[beat_q];
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = (beat_q == LAST_BEAT);
    assign m_axi_bready  = (state_q == S_WR_RESP);

    assign fill_valid    = fill_valid_q;
    assign fill_index    = fill_index_q;
    assign fill_data     = fill_data_q;
    assign done          = done_q;
    assign err           = err_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        buf_d        = buf_q;
        beat_d       = beat_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        sticky_d     = sticky_q;
        fill_valid_d = 1'b0;
        fill_index_d = fill_index_q;
        fill_data_d  = fill_data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        rd_err       = 1'b0;
        aw_done_n    = aw_done_q;
        w_done_n     = w_done_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d    = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    for (int i = 0; i < LINE_WORDS; i++) begin
                        buf_d[i] = req_wdata[32*i +: 32];
                    end
                    beat_d    = '0;
                    sticky_d  = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_write ? S_WR : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (m_axi_arready) begin
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (m_axi_rvalid) begin
                    // Beat count, not RLAST, ends the burst; a misplaced RLAST only flags an error.
                    rd_err       = (m_axi_rresp != 2'b00) || (m_axi_rlast != (beat_q == LAST_BEAT));
                    sticky_d     = sticky_q | rd_err;
                    fill_valid_d = 1'b1;
                    fill_index_d = beat_q;
                    fill_data_d  = m_axi_rdata;
                    beat_d       = beat_q + IDX_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        done_d  = 1'b1;
                        err_d   = sticky_q | rd_err;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WR: begin
                aw_done_n = aw_done_q | m_axi_awready;
                if (m_axi_wvalid && m_axi_wready) begin
                    beat_d   = beat_q + IDX_W'(1);
                    w_done_n = (beat_q == LAST_BEAT);
                end
                aw_done_d = aw_done_n;
                w_done_d  = w_done_n;
                if (aw_done_n && w_done_n) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (m_axi_bvalid) begin
                    done_d  = 1'b1;
                    err_d   = sticky_q | (m_axi_bresp != 2'b00);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                buf_q[i] <= '0;
            end
            beat_q       <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            sticky_q     <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_index_q <= '0;
            fill_data_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            buf_q        <= buf_d;
            beat_q       <= beat_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            sticky_q     <= sticky_d;
            fill_valid_q <= fill_valid_d;
            fill_index_q <= fill_index_d;
            fill_data_q  <= fill_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end
endmodule
